target_expander: RTL and testbench
==================================

# target_expander

Parametrised compact-target decoder for the mining datapath. It accepts a 32-bit compact difficulty word (nBits) over a valid/ready handshake and expands it into a TARGET_W-bit target using a multi-cycle byte shifter. It flags negative and overflowing encodings and holds the last committed target for downstream hash comparison. It sits between the block-header register file and the nonce-search cores.

## Interface
- TARGET_W, 256, target/hash width in bits; multiple of 8, minimum 32
- BYTES_PER_CYCLE, 4, left-shift bytes per SHIFT cycle; 1..TARGET_W/8
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- nbits_valid  in  1  compact word offered
- nbits_ready  out  1  high only in IDLE
- nbits  in  32  [31:24] exponent e, [23] sign, [22:0] mantissa m
- target_valid  out  1  result available; held until accepted
- target_ready  in  1  consumer accepts result
- target  out  TARGET_W  committed target register
- overflow  out  1  result flag, valid with target_valid
- negative  out  1  result flag, valid with target_valid
- busy  out  1  state != IDLE
- hash_valid  in  1  compare request (HASH_CMP_EN only)
- hash  in  TARGET_W  hash to compare
- meets_valid  out  1  compare result strobe
- meets_target  out  1  hash <= target

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: nbits_ready=1. On nbits_valid&&nbits_ready, capture nbits and go to LOAD.
- LOAD, one cycle. N=TARGET_W/8.
  - negative = sign && m!=0.
  - overflow = m!=0 && (e>N+2 || (m>0xFF && e>N+1) || (m>0xFFFF && e>N)).
  - If either flag is set, work register = 0, go to DONE.
  - If e<=3: work = m >> 8*(3-e), go to DONE.
  - Otherwise: work = m (zero-extended), remaining = e-3 bytes, go to SHIFT.
- SHIFT: each cycle, work <<= 8*min(BYTES_PER_CYCLE, remaining) and remaining is decremented by the same amount. Go to DONE when remaining reaches 0.
- Entering DONE: target, overflow and negative are loaded from work and the flags. A second register, tgt_ok, is set to !(overflow||negative).
- DONE: target_valid=1. On target_ready, go to IDLE.
- target keeps its value after the handshake until the next DONE entry.
- Sign bit with m==0 is not negative; the result is target=0, no flags.
- nbits is ignored outside IDLE.

## Timing
- Reset values: state IDLE, target=0, target_valid=0, overflow=0, negative=0, busy=0, meets_valid=0, meets_target=0, tgt_ok=0.
- Acceptance at edge T → LOAD during cycle T+1.
- target_valid rises at cycle T+2+ceil(s/BYTES_PER_CYCLE), where s=e-3 for e>3 and s=0 otherwise, or when a flag is set.
- Back-to-back: the earliest next acceptance is the cycle after the DONE handshake, because nbits_ready is registered from state.
- target_valid with target_ready low: target, flags and target_valid are held stable for any number of cycles.
- rst_n assertion mid-LOAD/SHIFT/DONE: the transaction is dropped and all registers return to reset values immediately (asynchronous).
- Compare path:
  - hash_valid at edge T → meets_valid=1 for exactly cycle T+1.
  - meets_target = tgt_ok && (hash <= target), evaluated against the committed target at edge T.
  - A compare issued during a new expansion uses the old committed target.
  - A compare that coincides with the DONE-entry edge also uses the old target.

## Configuration
- HASH_CMP_EN defined: comparator and meets registers are present as described.
- Not defined: hash_valid and hash are ignored, meets_valid and meets_target are tied 0, and no TARGET_W-bit comparator is synthesised.

## Test plan
- TARGET_W=256, BYTES_PER_CYCLE=4, nbits=0x1D00FFFF accepted at T → target_valid at T+9, target=0x00000000FFFF followed by 52 zero nibbles (0xFFFF<<208), no flags.
- nbits=0x03123456 → target=0x123456 at T+2. nbits=0x01123456 → target=0x12 at T+2.
- nbits=0x04923456 → negative=1, overflow=0, target=0 at T+2. nbits=0x21010000 → overflow=1, target=0. A compare of hash=0 afterwards → meets_target=0.
- target_ready held low 10 cycles after 0x1D00FFFF: target stable and nbits_ready=0 throughout. A second nbits is accepted only on the cycle after the handshake.
- With HASH_CMP_EN and target from 0x1D00FFFF:
  - hash=target → meets_target=1.
  - hash=target+1 → meets_target=0.
  - meets_valid is a single-cycle pulse.
  - A compare issued mid-expansion of 0x1C00FFFF uses the old target.
- rst_n pulsed low during SHIFT → target=0, busy=0 and target_valid=0 asynchronously. A fresh 0x1D00FFFF after release completes normally.

Source files
------------

// File: rtl/target_expander_if.sv
// Handshake and result bundle between the compact-target decoder and its neighbours.
// master = header register file / nonce cores side, slave = target_expander.
interface target_expander_if #(
    parameter int TARGET_W = 256
);
    logic                nbits_valid;
    logic                nbits_ready;
    logic [31:0]         nbits;
    logic                target_valid;
    logic                target_ready;
    logic [TARGET_W-1:0] target;
    logic                overflow;
    logic                negative;
    logic                busy;
    logic                hash_valid;
    logic [TARGET_W-1:0] hash;
    logic                meets_valid;
    logic                meets_target;

    modport master (
        output nbits_valid, nbits, target_ready, hash_valid, hash,
        input  nbits_ready, target_valid, target, overflow, negative, busy,
               meets_valid, meets_target
    );

    modport slave (
        input  nbits_valid, nbits, target_ready, hash_valid, hash,
        output nbits_ready, target_valid, target, overflow, negative, busy,
               meets_valid, meets_target
    );
endinterface

// File: rtl/target_expander.sv
// Expands a compact nBits word into a TARGET_W-bit target with a multi-cycle byte shifter.
// Optional hash <= target comparator is built only when HASH_CMP_EN is defined.
module target_expander #(
    parameter int TARGET_W        = 256,
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    target_expander_if.slave bus
);
    localparam int N = TARGET_W / 8;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [31:0]         nbits_q;
    logic [TARGET_W-1:0] work_q;
    logic [TARGET_W-1:0] target_q;
    logic [7:0]          rem_q;
    logic                nbits_ready_q;
    logic                target_valid_q;
    logic                busy_q;
    logic                overflow_q;
    logic                negative_q;
    logic                tgt_ok_q;

    logic [7:0]          e_w;
    logic [22:0]         m_w;
    logic                neg_w;
    logic                ovf_w;
    logic [7:0]          step_w;
    logic [TARGET_W-1:0] shifted_w;
    logic [TARGET_W-1:0] small_w;

    // Exponents 0..3 drop low mantissa bytes instead of shifting left.
    function automatic logic [TARGET_W-1:0] small_target(input logic [22:0] m,
                                                         input logic [7:0]  e);
        logic [22:0] v;
        unique case (e)
            8'd0:    v = '0;
            8'd1:    v = m >> 16;
            8'd2:    v = m >> 8;
            default: v = m;
        endcase
        return TARGET_W'(v);
    endfunction

    always_comb begin
        e_w       = nbits_q[31:24];
        m_w       = nbits_q[22:0];
        neg_w     = nbits_q[23] && (m_w != '0);
        ovf_w     = (m_w != '0) &&
                    ((int'(e_w) > N + 2) ||
                     ((m_w > 23'hFF)   && (int'(e_w) > N + 1)) ||
                     ((m_w > 23'hFFFF) && (int'(e_w) > N)));
        step_w    = (int'(rem_q) < BYTES_PER_CYCLE) ? rem_q : 8'(BYTES_PER_CYCLE);
        shifted_w = work_q << {step_w, 3'b000};
        small_w   = small_target(m_w, e_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            nbits_q        <= '0;
            work_q         <= '0;
            target_q       <= '0;
            rem_q          <= '0;
            nbits_ready_q  <= 1'b1;
            target_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
            negative_q     <= 1'b0;
            tgt_ok_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.nbits_valid && nbits_ready_q) begin
                        nbits_q       <= bus.nbits;
                        state_q       <= LOAD;
                        nbits_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (neg_w || ovf_w) begin
                        work_q         <= '0;
                        target_q       <= '0;
                        overflow_q     <= ovf_w;
                        negative_q     <= neg_w;
                        tgt_ok_q       <= 1'b0;
                        target_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else if (e_w <= 8'd3) begin
                        work_q         <= small_w;
                        target_q       <= small_w;
                        overflow_q     <= 1'b0;
                        negative_q     <= 1'b0;
                        tgt_ok_q       <= 1'b1;
                        target_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        work_q  <= TARGET_W'(m_w);
                        rem_q   <= e_w - 8'd3;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= shifted_w;
                    rem_q  <= rem_q - step_w;
                    // Last step commits the shifted value straight into the target.
                    if (rem_q == step_w) begin
                        target_q       <= shifted_w;
                        overflow_q     <= 1'b0;
                        negative_q     <= 1'b0;
                        tgt_ok_q       <= 1'b1;
                        target_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.target_ready) begin
                        target_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        nbits_ready_q  <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.nbits_ready  = nbits_ready_q;
    assign bus.target_valid = target_valid_q;
    assign bus.target       = target_q;
    assign bus.overflow     = overflow_q;
    assign bus.negative     = negative_q;
    assign bus.busy         = busy_q;

`ifdef HASH_CMP_EN
    logic meets_valid_q;
    logic meets_target_q;

    // Compares against target_q before any same-edge commit, so an in-flight expansion never leaks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meets_valid_q  <= 1'b0;
            meets_target_q <= 1'b0;
        end else begin
            meets_valid_q  <= bus.hash_valid;
            meets_target_q <= bus.hash_valid && tgt_ok_q && (bus.hash <= target_q);
        end
    end

    assign bus.meets_valid  = meets_valid_q;
    assign bus.meets_target = meets_target_q;
`else
    logic unused_cmp;
    assign unused_cmp       = ^{bus.hash_valid, bus.hash, tgt_ok_q};
    assign bus.meets_valid  = 1'b0;
    assign bus.meets_target = 1'b0;
`endif

endmodule

// File: tb/tb_target_expander.sv
// Directed bench for target_expander: scoreboard of expected expansions plus compare-path probes.
module tb_target_expander;

`ifdef HASH_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    typedef struct {
        logic [255:0] t;
        logic         o;
        logic         n;
        int           lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pcnt = 0;
    int   acc = 0;
    sb_t  sb[$];

    logic [255:0] T1D  = 256'hFFFF << 208;
    logic [255:0] T1C  = 256'hFFFF << 200;
    logic [255:0] T22  = 256'h1 << 248;

    target_expander_if #(.TARGET_W(256)) bus ();

    target_expander #(.TARGET_W(256), .BYTES_PER_CYCLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the LOAD cycle.
    task automatic send(input logic [31:0] nb, input logic [255:0] et,
                        input logic eo, input logic en, input int lat);
        int n;
        sb.push_back('{t: et, o: eo, n: en, lat: lat});
        n = 0;
        while (!bus.nbits_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check1("accept_ready", bus.nbits_ready, 1'b1);
        bus.nbits       = nb;
        bus.nbits_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc             = pcnt;
        bus.nbits_valid = 1'b0;
        bus.nbits       = 32'hFFFF_FFFF;
    endtask

    task automatic collect(input int hold);
        sb_t e;
        int  n;
        bit  stable;
        n = 0;
        while (!bus.target_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check1("target_valid", bus.target_valid, 1'b1);
        checki("sb_pending", sb.size(), 1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{t: '0, o: 1'b0, n: 1'b0, lat: 0};
        checki("latency", pcnt - acc + 1, e.lat);
        checkw("target", bus.target, e.t);
        check1("overflow", bus.overflow, e.o);
        check1("negative", bus.negative, e.n);
        check1("busy_done", bus.busy, 1'b1);
        check1("ready_in_done", bus.nbits_ready, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.target !== e.t || bus.target_valid !== 1'b1 ||
                bus.nbits_ready !== 1'b0 || bus.overflow !== e.o || bus.negative !== e.n)
                stable = 1'b0;
        end
        if (hold > 0) check1("hold_stable", stable, 1'b1);
        bus.target_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.target_ready = 1'b0;
        check1("tv_dropped", bus.target_valid, 1'b0);
        check1("ready_after_hs", bus.nbits_ready, 1'b1);
        checkw("target_kept", bus.target, e.t);
    endtask

    task automatic cmp(input logic [255:0] h, input logic exp_mt, input bit chk_pulse);
        bus.hash       = h;
        bus.hash_valid = 1'b1;
        @(negedge clk);
        bus.hash_valid = 1'b0;
        check1("meets_valid", bus.meets_valid, CMP);
        check1("meets_target", bus.meets_target, CMP & exp_mt);
        if (chk_pulse) begin
            @(negedge clk);
            check1("meets_pulse", bus.meets_valid, 1'b0);
        end
    endtask

    initial begin
        bus.nbits_valid  = 1'b0;
        bus.nbits        = '0;
        bus.target_ready = 1'b0;
        bus.hash_valid   = 1'b0;
        bus.hash         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkw("rst_target", bus.target, '0);
        check1("rst_tv", bus.target_valid, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_ovf", bus.overflow, 1'b0);
        check1("rst_neg", bus.negative, 1'b0);
        check1("rst_mv", bus.meets_valid, 1'b0);
        check1("rst_mt", bus.meets_target, 1'b0);
        check1("rst_ready", bus.nbits_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Main expansion with a stalled consumer, then back-to-back small exponents
        send(32'h1D00FFFF, T1D, 1'b0, 1'b0, 9);
        collect(10);
        send(32'h03123456, 256'h123456, 1'b0, 1'b0, 2);
        collect(0);
        send(32'h01123456, 256'h12, 1'b0, 1'b0, 2);
        collect(0);
        send(32'h04923456, '0, 1'b0, 1'b1, 2);
        collect(0);
        send(32'h21010000, '0, 1'b1, 1'b0, 2);
        collect(0);
        cmp('0, 1'b0, 1'b1);
        send(32'h22000001, T22, 1'b0, 1'b0, 10);
        collect(0);
        send(32'h04800000, '0, 1'b0, 1'b0, 3);
        collect(0);
        send(32'h04123456, 256'h12345600, 1'b0, 1'b0, 3);
        collect(0);
        send(32'h00123456, '0, 1'b0, 1'b0, 2);
        collect(2);

        // Compare path against the 0x1D00FFFF target
        send(32'h1D00FFFF, T1D, 1'b0, 1'b0, 9);
        collect(0);
        cmp(T1D, 1'b1, 1'b1);
        cmp(T1D + 256'd1, 1'b0, 1'b1);
        cmp(256'd1, 1'b1, 1'b1);

        // Compares during a new expansion and on its DONE-entry edge see the old target
        send(32'h1C00FFFF, T1C, 1'b0, 1'b0, 9);
        repeat (2) @(negedge clk);
        cmp(T1D, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        cmp(T1D, 1'b1, 1'b0);
        collect(0);
        cmp(T1D, 1'b0, 1'b1);

        // Asynchronous reset in the middle of SHIFT
        send(32'h1D00FFFF, T1D, 1'b0, 1'b0, 9);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkw("arst_target", bus.target, '0);
        check1("arst_busy", bus.busy, 1'b0);
        check1("arst_tv", bus.target_valid, 1'b0);
        check1("arst_ready", bus.nbits_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp(256'd0, 1'b0, 1'b1);
        send(32'h1D00FFFF, T1D, 1'b0, 1'b0, 9);
        collect(0);
        cmp(T1D, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
